// File: rtl/sam_fasta_pkg.sv
// Shared constants and state encoding for the SAM-to-FASTA converter.
package sam_fasta_pkg;

    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_NUL = 8'h00;
    localparam logic [7:0] CH_AT  = 8'h40;
    localparam logic [7:0] CH_GT  = 8'h3E;

    localparam logic [3:0] SEQ_FIELD = 4'd10;

    typedef enum logic [2:0] {
        S_LINE_START  = 3'd0,
        S_HDR_SKIP    = 3'd1,
        S_QNAME       = 3'd2,
        S_SKIP_FIELDS = 3'd3,
        S_SEQ         = 3'd4,
        S_REST        = 3'd5,
        S_DONE        = 3'd6
    } state_t;

    function automatic logic is_sep(input logic [7:0] b);
        return (b == CH_SP) || (b == CH_TAB);
    endfunction

endpackage

// File: rtl/sam_to_fasta_fsm_rom_byte_stream.sv
// Byte fetcher for a synchronous ROM: address register, data-valid tracking
// and end-of-input detection (NUL byte or IN_LEN bytes consumed).
module rom_byte_stream
    import sam_fasta_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int IN_LEN     = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_rom_data,
    input  logic                  i_take,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    output logic                  o_valid,
    output logic                  o_end
);

    localparam logic [ADDR_WIDTH:0] LEN_LIMIT = (ADDR_WIDTH+1)'(IN_LEN);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_valid;
    logic                  w_at_limit;

    // Handshake: o_valid says rom_data holds the byte at o_rom_addr; i_take
    // consumes it only while o_valid is high, otherwise the address is held.
    assign w_at_limit = (r_count == LEN_LIMIT);
    assign o_end      = w_at_limit || (r_valid && (i_rom_data == CH_NUL));
    assign o_valid    = r_valid && !o_end;
    assign o_rom_addr = r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (i_take && o_valid) begin
            r_addr  <= r_addr + 1'b1;
            r_count <= r_count + 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/sam_to_fasta_fsm.sv
// Streams SAM text from a byte ROM and writes ">QNAME\nSEQ\n" records to a
// byte RAM, dropping header lines. Runs once after reset.
module sam_to_fasta_fsm
    import sam_fasta_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int IN_LEN     = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_data,
    output logic                  ram_we,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] out_len,
    output logic                  err_malformed,
    output logic                  err_overflow,
    output logic [2:0]            dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

    state_t                r_state, w_next;
    logic [3:0]            r_field_cnt;
    logic [ADDR_WIDTH-1:0] r_ptr, r_ram_addr;
    logic [7:0]            r_ram_data, w_wr_byte;
    logic                  r_ram_we, r_err_mal, r_err_ovf;
    logic                  w_valid, w_end, w_take, w_wr, w_set_mal;
    logic                  w_cnt_load, w_cnt_inc, w_ovf, w_sep, w_lf, w_cr;

    rom_byte_stream #(.ADDR_WIDTH(ADDR_WIDTH), .IN_LEN(IN_LEN)) u_stream (
        .clk        (clk),
        .rst        (rst),
        .i_rom_data (rom_data),
        .i_take     (w_take),
        .o_rom_addr (rom_addr),
        .o_valid    (w_valid),
        .o_end      (w_end)
    );

    assign w_sep = is_sep(rom_data);
    assign w_lf  = (rom_data == CH_LF);
    assign w_cr  = (rom_data == CH_CR);
    assign w_ovf = w_wr && (r_ptr == PTR_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LINE_START;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LINE_START: begin
                if (w_end) w_next = S_DONE;
                else if (w_valid) begin
                    if (rom_data == CH_AT)  w_next = S_HDR_SKIP;
                    else if (!w_lf && !w_cr) w_next = S_QNAME;
                end
            end
            S_HDR_SKIP, S_REST: begin
                if (w_end) w_next = S_DONE;
                else if (w_valid && w_lf) w_next = S_LINE_START;
            end
            S_QNAME: begin
                if (w_end) w_next = S_DONE;
                else if (w_valid && w_lf)  w_next = S_LINE_START;
                else if (w_valid && w_sep) w_next = S_SKIP_FIELDS;
            end
            S_SKIP_FIELDS: begin
                if (w_end) w_next = S_DONE;
                else if (w_valid && w_lf) w_next = S_LINE_START;
                else if (w_valid && w_sep && (r_field_cnt == SEQ_FIELD - 4'd1)) w_next = S_SEQ;
            end
            S_SEQ: begin
                if (w_end) w_next = S_DONE;
                else if (w_valid && w_lf)  w_next = S_LINE_START;
                else if (w_valid && w_sep) w_next = S_REST;
            end
            default: w_next = S_DONE;
        endcase
        if (w_ovf) w_next = S_DONE;
    end

    // The first byte of a record is left unconsumed so QNAME sees it after '>'.
    always_comb begin
        w_take     = 1'b0;
        w_wr       = 1'b0;
        w_wr_byte  = 8'h00;
        w_set_mal  = 1'b0;
        w_cnt_load = 1'b0;
        w_cnt_inc  = 1'b0;
        case (r_state)
            S_LINE_START: begin
                if (!w_end && w_valid) begin
                    if (w_cr || w_lf || rom_data == CH_AT) w_take = 1'b1;
                    else begin
                        w_wr      = 1'b1;
                        w_wr_byte = CH_GT;
                    end
                end
            end
            S_HDR_SKIP, S_REST: w_take = !w_end && w_valid;
            S_QNAME: begin
                if (w_end) begin
                    w_wr      = 1'b1;
                    w_wr_byte = CH_LF;
                    w_set_mal = 1'b1;
                end else if (w_valid) begin
                    w_take = 1'b1;
                    if (w_lf) begin
                        w_wr      = 1'b1;
                        w_wr_byte = CH_LF;
                        w_set_mal = 1'b1;
                    end else if (w_sep) begin
                        w_wr       = 1'b1;
                        w_wr_byte  = CH_LF;
                        w_cnt_load = 1'b1;
                    end else if (!w_cr) begin
                        w_wr      = 1'b1;
                        w_wr_byte = rom_data;
                    end
                end
            end
            S_SKIP_FIELDS: begin
                if (w_end) w_set_mal = 1'b1;
                else if (w_valid) begin
                    w_take = 1'b1;
                    if (w_lf) begin
                        w_wr      = 1'b1;
                        w_wr_byte = CH_LF;
                        w_set_mal = 1'b1;
                    end else if (w_sep) w_cnt_inc = 1'b1;
                end
            end
            S_SEQ: begin
                if (w_end) begin
                    w_wr      = 1'b1;
                    w_wr_byte = CH_LF;
                end else if (w_valid) begin
                    w_take = 1'b1;
                    if (w_lf || w_sep) begin
                        w_wr      = 1'b1;
                        w_wr_byte = CH_LF;
                    end else if (!w_cr) begin
                        w_wr      = 1'b1;
                        w_wr_byte = rom_data;
                    end
                end
            end
            default: ;
        endcase
    end

    // The pointer saturates at the last address, so out_len reads 2**ADDR_WIDTH-1 after overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_ram_addr  <= '0;
            r_ram_data  <= 8'h00;
            r_ram_we    <= 1'b0;
            r_field_cnt <= 4'd0;
            r_err_mal   <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_ram_we <= w_wr;
            if (w_wr) begin
                r_ram_addr <= r_ptr;
                r_ram_data <= w_wr_byte;
                if (r_ptr != PTR_MAX) r_ptr <= r_ptr + 1'b1;
            end
            if (w_cnt_load) r_field_cnt <= 4'd2;
            else if (w_cnt_inc && r_field_cnt != SEQ_FIELD) r_field_cnt <= r_field_cnt + 4'd1;
            if (w_set_mal) r_err_mal <= 1'b1;
            if (w_ovf)     r_err_ovf <= 1'b1;
        end
    end

    assign ram_addr      = r_ram_addr;
    assign ram_data      = r_ram_data;
    assign ram_we        = r_ram_we;
    assign out_len       = r_ptr;
    assign done          = (r_state == S_DONE);
    assign err_malformed = r_err_mal;
    assign err_overflow  = r_err_ovf;
    assign dbg_state     = r_state;

endmodule
